// File: rtl/bus_rr_router.sv
// Round-robin shared-bus router: pops one packet per grant from the device FIFOs and routes it by header ID.
// Define BUS_BCAST_EN to deliver the broadcast ID to every device except the source.
`timescale 1ns/1ps
module bus_rr_router #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         cnt_w     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push,
  output logic                       busy,
  output logic [cnt_w-1:0]           drop_cnt
);

  localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, ROUTE} state_t;

  state_t             state;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      grant_q;
  logic [GW-1:0]      arb_idx;
  logic [drvrs-1:0]   arb_onehot;
  logic [drvrs-1:0]   route_mask;
  logic [pckg_sz-1:0] lane;
  logic [7:0]         dst;
  logic               is_drop;

  // Descending scan so the requester closest to rr_ptr is the one left in arb_idx.
  always_comb begin : arbiter
    int t;
    t = 0;
    arb_idx = '0;
    for (int k = drvrs - 1; k >= 0; k--) begin
      t = int'(rr_ptr) + k;
      if (t >= drvrs) t = t - drvrs;
      if (pndng[t]) arb_idx = GW'(t);
    end
    for (int i = 0; i < drvrs; i++) arb_onehot[i] = (i == int'(arb_idx));
  end

  always_comb begin : router
    lane       = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
    dst        = lane[pckg_sz-1 -: 8];
    route_mask = '0;
    is_drop    = 1'b0;
    if (dst == broadcast) begin
`ifdef BUS_BCAST_EN
      for (int i = 0; i < drvrs; i++) route_mask[i] = (i != int'(grant_q));
`else
      is_drop = 1'b1;
`endif
    end else if ((int'(dst) < drvrs) && (int'(dst) != int'(grant_q))) begin
      for (int i = 0; i < drvrs; i++) route_mask[i] = (i == int'(dst));
    end else begin
      is_drop = 1'b1;
    end
  end

  // The routing decision is made while the granted lane is still at the FIFO head,
  // so push is already registered for the ROUTE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      rr_ptr   <= '0;
      grant_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          push <= '0;
          if (|pndng) begin
            grant_q <= arb_idx;
            pop     <= arb_onehot;
            busy    <= 1'b1;
            state   <= POP;
          end
        end
        POP: begin
          pop    <= '0;
          push   <= route_mask;
          D_push <= {drvrs{lane}};
          if (is_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + cnt_w'(1);
          rr_ptr <= (int'(grant_q) == drvrs - 1) ? '0 : grant_q + GW'(1);
          state  <= ROUTE;
        end
        ROUTE: begin
          push  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          pop   <= '0;
          push  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
